// File: rtl/xbar_slave_arbiter.sv
// xbar_slave_arbiter: round-robin arbiter sharing one crossbar slave port
// among four masters. It holds the grant until the slave acknowledges or a
// timeout expires, and routes the acknowledge back to the owning master only.
module xbar_slave_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [3:0]   m_req,
  input  logic [3:0]   m_cmd,
  input  logic [127:0] m_addr,
  input  logic [127:0] m_wdata,
  output logic [3:0]   m_ack,
  output logic         m_err,
  output logic [31:0]  m_rdata,
  output logic         s_req,
  output logic         s_cmd,
  output logic [31:0]  s_addr,
  output logic [31:0]  s_wdata,
  input  logic         s_ack,
  input  logic [31:0]  s_rdata,
  output logic [3:0]   grant
);

  // Counter is wide enough to hold TIMEOUT; one bit when the timeout is off.
  localparam int            CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit            TMO_EN   = (TIMEOUT != 0);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_RDATA
  } state_t;

  state_t        state;
  logic [1:0]    ptr;
  logic [CW-1:0] cnt;
  logic [1:0]    winner;
  logic [1:0]    idx;
  logic          tmo_hit;

  // Round-robin pick: scan from the highest offset down so the requester
  // closest to ptr is the last (and therefore winning) assignment.
  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    winner = ptr;
    idx    = ptr;
    for (int i = 3; i >= 0; i--) begin
      idx = ptr + 2'(i);
      if (m_req[idx]) winner = idx;
    end
  end

  // Timeout fires on the TIMEOUT-th busy cycle unless the slave acks then.
  assign tmo_hit = TMO_EN && (state == ST_BUSY) && (cnt == CNT_LAST) && !s_ack;

  // Acknowledge routing: only the granted master sees the slave's ack.
  always_comb begin
    m_ack = 4'b0000;
    m_err = 1'b0;
    if (state == ST_BUSY) begin
      if (s_ack) begin
        m_ack = grant;
      end else if (tmo_hit) begin
        m_ack = grant;
        m_err = 1'b1;
      end
    end
  end

  assign m_rdata = s_rdata;

  // Arbitration FSM with registered slave-side outputs and grant.
  // NOTE: nonblocking assignments so every register samples pre-edge values
  // regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      ptr     <= 2'd0;
      cnt     <= '0;
      grant   <= 4'b0000;
      s_req   <= 1'b0;
      s_cmd   <= 1'b0;
      s_addr  <= 32'd0;
      s_wdata <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|m_req) begin
            grant   <= 4'b0001 << winner;
            s_req   <= 1'b1;
            s_cmd   <= m_cmd[winner];
            s_addr  <= m_addr[{winner, 5'd0} +: 32];
            s_wdata <= m_wdata[{winner, 5'd0} +: 32];
            ptr     <= winner + 2'd1;
            cnt     <= '0;
            state   <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (s_ack) begin
            s_req <= 1'b0;
            if (!s_cmd) begin
              state <= ST_RDATA;
            end else begin
              grant <= 4'b0000;
              state <= ST_IDLE;
            end
          end else if (tmo_hit) begin
            s_req <= 1'b0;
            grant <= 4'b0000;
            state <= ST_IDLE;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_RDATA: begin
          grant <= 4'b0000;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xbar_slave_arbiter.sv
// Testbench for xbar_slave_arbiter: randomized and directed request batches,
// a reactive slave model, and a scoreboard monitor checking every ack.
module tb_xbar_slave_arbiter;

  localparam int TMO = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   m_req;
  logic [3:0]   m_cmd;
  logic [127:0] m_addr;
  logic [127:0] m_wdata;
  logic [3:0]   m_ack;
  logic         m_err;
  logic [31:0]  m_rdata;
  logic         s_req;
  logic         s_cmd;
  logic [31:0]  s_addr;
  logic [31:0]  s_wdata;
  logic         s_ack;
  logic [31:0]  s_rdata;
  logic [3:0]   grant;

  xbar_slave_arbiter #(.TIMEOUT(TMO)) dut (
    .clk     (clk),
    .reset   (reset),
    .m_req   (m_req),
    .m_cmd   (m_cmd),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_ack   (m_ack),
    .m_err   (m_err),
    .m_rdata (m_rdata),
    .s_req   (s_req),
    .s_cmd   (s_cmd),
    .s_addr  (s_addr),
    .s_wdata (s_wdata),
    .s_ack   (s_ack),
    .s_rdata (s_rdata),
    .grant   (grant)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          master;
    bit          cmd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          lat;
    bit          err;
  } txn_t;

  txn_t exp_q[$];
  txn_t slv_q[$];

  int checks    = 0;
  int failures  = 0;
  int ptr_model = 0;
  bit stray     = 1'b0;

  bit          b_cmd   [4];
  logic [31:0] b_addr  [4];
  logic [31:0] b_wdata [4];
  logic [31:0] b_rdata [4];
  int          b_lat   [4];

  int   mon_busy  = 0;
  int   mon_phase = 0;
  txn_t mon_cur;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic rand_fields();
    for (int i = 0; i < 4; i++) begin
      b_cmd[i]   = 1'($urandom_range(0, 1));
      b_addr[i]  = $urandom();
      b_wdata[i] = $urandom();
      b_rdata[i] = $urandom();
      b_lat[i]   = $urandom_range(1, TMO + 2);
    end
  endtask

  // Issue one batch: the masters in mask request together and each drops its
  // request once acked. Expected service order is the circular order of the
  // requesting masters starting at the model pointer.
  task automatic run_batch(input logic [3:0] mask);
    txn_t       e;
    int         last  = 0;
    int         first = -1;
    int         n     = 0;
    logic [3:0] acked;
    for (int k = 0; k < 4; k++) begin
      int m;
      m = (ptr_model + k) % 4;
      if (mask[m]) begin
        e.master = m;
        e.cmd    = b_cmd[m];
        e.addr   = b_addr[m];
        e.wdata  = b_wdata[m];
        e.rdata  = b_rdata[m];
        e.lat    = b_lat[m];
        e.err    = (b_lat[m] > TMO);
        exp_q.push_back(e);
        slv_q.push_back(e);
        if (first < 0) first = m;
        last = m;
      end
    end
    ptr_model = (last + 1) % 4;
    for (int i = 0; i < 4; i++) begin
      m_cmd[i]             = b_cmd[i];
      m_addr[32*i +: 32]   = b_addr[i];
      m_wdata[32*i +: 32]  = b_wdata[i];
    end
    m_req = mask;
    while (m_req != 4'b0000 && n < 200) begin
      @(negedge clk);
      if (n == 0) check("idle_before_grant", s_req, 1'b0);
      if (n == 1) begin
        check("grant_latency", s_req, 1'b1);
        check("grant_first", grant, 4'b0001 << first);
        check("s_addr_first", s_addr, b_addr[first]);
        check("s_wdata_first", s_wdata, b_wdata[first]);
      end
      acked = m_ack;
      @(posedge clk);
      #1;
      m_req = m_req & ~acked;
      n++;
    end
    check("batch_done", m_req, 4'b0000);
    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
  endtask

  // Slave model: acks the lat-th busy cycle of each transfer (never if lat
  // exceeds the timeout) and drives read data the cycle after the ack.
  initial begin
    bit   active   = 1'b0;
    bit   prev_ack = 1'b0;
    int   cyc      = 0;
    txn_t cur;
    cur.lat   = 1;
    cur.rdata = 32'd0;
    s_ack     = 1'b0;
    s_rdata   = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        active   = 1'b0;
        prev_ack = 1'b0;
        s_ack    = 1'b0;
      end else begin
        s_rdata = prev_ack ? cur.rdata : $urandom();
        if (s_req) begin
          if (!active) begin
            active = 1'b1;
            cyc    = 1;
            if (slv_q.size() > 0) begin
              cur = slv_q.pop_front();
            end else begin
              cur.lat   = 1;
              cur.rdata = 32'd0;
            end
          end else begin
            cyc++;
          end
        end else begin
          active = 1'b0;
        end
        prev_ack = active && (cyc == cur.lat);
        s_ack    = prev_ack || stray;
      end
    end
  end

  // Scoreboard monitor: every m_ack pops one expected completion.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        mon_busy  = 0;
        mon_phase = 0;
      end else begin
        mon_busy = s_req ? mon_busy + 1 : 0;
        if (mon_phase == 2) begin
          check("rdata_value", m_rdata, mon_cur.rdata);
          check("rdata_grant_held", grant, 4'b0001 << mon_cur.master);
          check("rdata_s_req_low", s_req, 1'b0);
          mon_phase = 3;
        end else if (mon_phase != 0) begin
          check("idle_grant_zero", grant, 4'b0000);
          check("idle_s_req_low", s_req, 1'b0);
          mon_phase = 0;
        end
        if (m_ack != 4'b0000) begin
          if (exp_q.size() == 0) begin
            check("unexpected_ack", m_ack, 4'b0000);
          end else begin
            mon_cur = exp_q.pop_front();
            check("ack_master", m_ack, 4'b0001 << mon_cur.master);
            check("ack_err", m_err, mon_cur.err);
            check("ack_grant", grant, 4'b0001 << mon_cur.master);
            check("ack_cmd", s_cmd, mon_cur.cmd);
            check("ack_addr", s_addr, mon_cur.addr);
            check("ack_wdata", s_wdata, mon_cur.wdata);
            check("ack_cycle", mon_busy, mon_cur.err ? TMO : mon_cur.lat);
            mon_phase = (!mon_cur.err && !mon_cur.cmd) ? 2 : 1;
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b1;
    m_req   = 4'b0000;
    m_cmd   = 4'b0000;
    m_addr  = 128'd0;
    m_wdata = 128'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_grant", grant, 4'b0000);
    check("rst_s_req", s_req, 1'b0);
    check("rst_s_cmd", s_cmd, 1'b0);
    check("rst_s_addr", s_addr, 32'd0);
    check("rst_s_wdata", s_wdata, 32'd0);
    check("rst_m_ack", m_ack, 4'b0000);
    check("rst_m_err", m_err, 1'b0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // All four masters, immediate acks, twice: order 0,1,2,3,0,1,2,3.
    for (int r = 0; r < 2; r++) begin
      rand_fields();
      for (int i = 0; i < 4; i++) begin
        b_cmd[i] = 1'b1;
        b_lat[i] = 1;
      end
      run_batch(4'b1111);
    end

    // Master 2 write, acked on the third busy cycle.
    rand_fields();
    b_cmd[2] = 1'b1; b_addr[2] = 32'h0000_0010; b_wdata[2] = 32'hA5A5_A5A5; b_lat[2] = 3;
    run_batch(4'b0100);

    // Master 1 read returning 0xDEADBEEF.
    rand_fields();
    b_cmd[1] = 1'b0; b_rdata[1] = 32'hDEAD_BEEF; b_lat[1] = 1;
    run_batch(4'b0010);

    // Master 3 write, slave never acks: timeout with error.
    rand_fields();
    b_cmd[3] = 1'b1; b_lat[3] = TMO + 5;
    run_batch(4'b1000);

    // Ack on the timeout cycle wins: normal completion, no error.
    rand_fields();
    b_cmd[0] = 1'b1; b_lat[0] = TMO;
    run_batch(4'b0001);

    // Stray acks while idle produce nothing.
    #1 stray = 1'b1;
    @(posedge clk);
    #1;
    repeat (2) begin
      @(negedge clk);
      check("stray_no_ack", m_ack, 4'b0000);
      check("stray_idle", grant, 4'b0000);
    end
    @(posedge clk);
    #2 stray = 1'b0;
    @(posedge clk);
    #1;

    // Randomized batches.
    for (int r = 0; r < 40; r++) begin
      rand_fields();
      run_batch(4'($urandom_range(1, 15)));
    end

    // Reset in the middle of a master-0 transfer.
    rand_fields();
    b_cmd[0] = 1'b1; b_addr[0] = 32'hCAFE_0000; b_wdata[0] = 32'h1234_5678; b_lat[0] = 100;
    m_cmd[0]        = 1'b1;
    m_addr[31:0]    = b_addr[0];
    m_wdata[31:0]   = b_wdata[0];
    slv_q.push_back('{master: 0, cmd: 1'b1, addr: b_addr[0], wdata: b_wdata[0],
                      rdata: 32'd0, lat: 100, err: 1'b0});
    m_req = 4'b0001;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("pre_reset_grant", grant, 4'b0001);
    #2 reset = 1'b1;
    #1;
    check("midrst_grant", grant, 4'b0000);
    check("midrst_s_req", s_req, 1'b0);
    check("midrst_s_addr", s_addr, 32'd0);
    check("midrst_s_wdata", s_wdata, 32'd0);
    check("midrst_s_cmd", s_cmd, 1'b0);
    check("midrst_m_ack", m_ack, 4'b0000);
    check("midrst_m_err", m_err, 1'b0);
    m_req = 4'b0000;
    exp_q.delete();
    slv_q.delete();
    ptr_model = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // After reset the pointer is back at 0: master 0 wins over master 3.
    rand_fields();
    b_cmd[0] = 1'b1; b_lat[0] = 2;
    b_cmd[3] = 1'b1; b_lat[3] = 1;
    run_batch(4'b1001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
